// File: rtl/iir_pkg.sv
// iir_pkg: shared constants, state encoding and helpers for the biquad coefficient loader.
package iir_pkg;

  localparam int unsigned COEFFS_PER_STAGE = 5;

  localparam int unsigned IDX_B0 = 0;
  localparam int unsigned IDX_B1 = 1;
  localparam int unsigned IDX_B2 = 2;
  localparam int unsigned IDX_A1 = 3;
  localparam int unsigned IDX_A2 = 4;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DISCARD = 2'd1,
    CHECK   = 2'd2,
    PENDING = 2'd3
  } state_e;

  // Q-format representation of 1.0
  function automatic int unsigned unity_val(input int unsigned frac_bits);
    return 32'd1 << frac_bits;
  endfunction

endpackage

// File: rtl/iir_coeff_stage_check.sv
// iir_coeff_stage_check: combinational stability screen of one biquad denominator
// (1 + a1 z^-1 + a2 z^-2), evaluated with two guard bits so no compare can overflow.
module iir_coeff_stage_check
  import iir_pkg::*;
#(
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned FRAC_BITS   = 14
) (
  input  logic signed [COEFF_WIDTH-1:0] a1,
  input  logic signed [COEFF_WIDTH-1:0] a2,
  output logic                          stable_c
);

  localparam int unsigned CW = COEFF_WIDTH + 2;
  localparam logic signed [CW-1:0] UNITY = CW'(unity_val(FRAC_BITS));

  logic signed [CW-1:0] a1_x;
  logic signed [CW-1:0] a2_x;
  logic signed [CW-1:0] a1_abs;
  logic signed [CW-1:0] a2_abs;

  // Stability triangle: |a2| < 1 and |a1| < 1 + a2
  always_comb begin
    a1_x     = CW'(a1);
    a2_x     = CW'(a2);
    a1_abs   = a1_x[CW-1] ? -a1_x : a1_x;
    a2_abs   = a2_x[CW-1] ? -a2_x : a2_x;
    stable_c = (a2_abs < UNITY) && (a1_abs < (UNITY + a2_x));
  end

endmodule

// File: rtl/iir_coeff_loader.sv
// iir_coeff_loader: assembles serial biquad coefficient sets in a shadow bank and commits
// them to the active bank on a sample boundary. Define IIR_COEFF_STABILITY_CHECK_EN to screen sets.
module iir_coeff_loader
  import iir_pkg::*;
#(
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned FRAC_BITS   = 14
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic signed [COEFF_WIDTH-1:0]                       coeff_in,
  input  logic                                                coeff_valid,
  input  logic                                                coeff_last,
  output logic                                                coeff_ready,
  input  logic                                                sample_strobe,
  output logic [NUM_STAGES*COEFFS_PER_STAGE*COEFF_WIDTH-1:0]  coeff_out,
  output logic                                                coeff_update,
  output logic                                                err_short,
  output logic                                                err_long,
  output logic                                                err_unstable,
  output logic                                                busy
);

  localparam int unsigned NUM_COEFFS = NUM_STAGES * COEFFS_PER_STAGE;
  localparam int unsigned OUT_W      = NUM_COEFFS * COEFF_WIDTH;
  localparam int unsigned CNT_W      = $clog2(NUM_COEFFS);
  localparam logic [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(unity_val(FRAC_BITS));

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [COEFF_WIDTH-1:0]   shadow_q [NUM_COEFFS];
  logic [COEFF_WIDTH-1:0]   shadow_d [NUM_COEFFS];
  logic [OUT_W-1:0]         active_q, active_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic                     update_q, update_d;
  logic                     short_q, short_d;
  logic                     long_q, long_d;
  logic                     unstable_d;
  logic                     accept;
  logic                     stage_ok_c;
  logic [OUT_W-1:0]         shadow_bank;
  logic [OUT_W-1:0]         reset_bank;

  // Flatten shadow bank and build the pass-through reset image
  for (genvar g = 0; g < NUM_COEFFS; g++) begin : g_pack
    assign shadow_bank[g*COEFF_WIDTH +: COEFF_WIDTH] = shadow_q[g];
    assign reset_bank[g*COEFF_WIDTH +: COEFF_WIDTH] =
      ((g % COEFFS_PER_STAGE) == IDX_B0) ? UNITY : '0;
  end

`ifdef IIR_COEFF_STABILITY_CHECK_EN
  logic [CNT_W-1:0] a1_idx;
  logic [CNT_W-1:0] a2_idx;
  logic             unstable_q;

  // In CHECK the counter walks stages, not words
  assign a1_idx = CNT_W'(cnt_q * CNT_W'(COEFFS_PER_STAGE)) + CNT_W'(IDX_A1);
  assign a2_idx = CNT_W'(cnt_q * CNT_W'(COEFFS_PER_STAGE)) + CNT_W'(IDX_A2);

  iir_coeff_stage_check #(
    .COEFF_WIDTH (COEFF_WIDTH),
    .FRAC_BITS   (FRAC_BITS)
  ) u_stage_check (
    .a1       (shadow_q[a1_idx]),
    .a2       (shadow_q[a2_idx]),
    .stable_c (stage_ok_c)
  );

  always_ff @(posedge clk) begin
    if (rst) unstable_q <= 1'b0;
    else     unstable_q <= unstable_d;
  end
  assign err_unstable = unstable_q;
`else
  assign stage_ok_c   = 1'b1;
  assign err_unstable = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    update_d   = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    unstable_d = 1'b0;
    accept     = coeff_valid && ready_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          shadow_d[cnt_q] = coeff_in;
          cnt_d           = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_COEFFS - 1)) begin
            cnt_d = '0;
            if (coeff_last) begin
`ifdef IIR_COEFF_STABILITY_CHECK_EN
              state_d = CHECK;
`else
              state_d = PENDING;
`endif
            end else begin
              long_d  = 1'b1;
              state_d = DISCARD;
            end
          end else if (coeff_last) begin
            short_d = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      DISCARD: begin
        if (accept && coeff_last) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
`ifdef IIR_COEFF_STABILITY_CHECK_EN
      CHECK: begin
        if (!stage_ok_c) begin
          unstable_d = 1'b1;
          state_d    = FILL;
          cnt_d      = '0;
        end else if (cnt_q == CNT_W'(NUM_STAGES - 1)) begin
          state_d = PENDING;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      PENDING: begin
        if (sample_strobe) begin
          active_d = shadow_bank;
          update_d = 1'b1;
          state_d  = FILL;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == FILL) || (state_d == DISCARD);
    busy_d  = (state_d != FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      active_q <= reset_bank;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      update_q <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      update_q <= update_d;
      short_q  <= short_d;
      long_q   <= long_d;
    end
  end

  // Shadow contents are meaningless until a full set lands, so no reset
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign coeff_out    = active_q;
  assign coeff_ready  = ready_q;
  assign coeff_update = update_q;
  assign err_short    = short_q;
  assign err_long     = long_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// tb_iir_coeff_loader: directed stimulus against a set-level behavioural model of the loader,
// compared every cycle, plus hand-computed literal expectations.
module tb_iir_coeff_loader;

  localparam int unsigned W     = 16;
  localparam int unsigned NS    = 2;
  localparam int unsigned FB    = 14;
  localparam int unsigned N     = NS * 5;
  localparam int unsigned OUT_W = N * W;
`ifdef IIR_COEFF_STABILITY_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [OUT_W-1:0] PASS = {16'h0, 16'h0, 16'h0, 16'h0, 16'h4000,
                                       16'h0, 16'h0, 16'h0, 16'h0, 16'h4000};
  localparam logic [OUT_W-1:0] SET1 = {16'd10, 16'd9, 16'd8, 16'd7, 16'd6,
                                       16'd5, 16'd4, 16'd3, 16'd2, 16'd1};

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [W-1:0]  coeff_in = '0;
  logic                 coeff_valid = 1'b0;
  logic                 coeff_last = 1'b0;
  logic                 coeff_ready;
  logic                 sample_strobe = 1'b0;
  logic [OUT_W-1:0]     coeff_out;
  logic                 coeff_update, err_short, err_long, err_unstable, busy;

  always #5 clk = ~clk;

  iir_coeff_loader dut (
    .clk(clk), .rst(rst), .coeff_in(coeff_in), .coeff_valid(coeff_valid),
    .coeff_last(coeff_last), .coeff_ready(coeff_ready), .sample_strobe(sample_strobe),
    .coeff_out(coeff_out), .coeff_update(coeff_update), .err_short(err_short),
    .err_long(err_long), .err_unstable(err_unstable), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- set-level behavioural model ----------------
  int m_bank [N];
  int pend   [N];
  int cur    [$];
  bit model_on = 1'b0;
  bit m_ready, m_busy, m_update, m_short, m_long, m_unst, m_waiting, m_drop;
  int m_check_left;

  function automatic bit stage_ok(input int a1, input int a2);
    int u;
    u = 1 << FB;
    return ((a2 < 0 ? -a2 : a2) < u) && ((a1 < 0 ? -a1 : a1) < u + a2);
  endfunction

  function automatic logic [OUT_W-1:0] bank_vec();
    logic [OUT_W-1:0] v;
    v = '0;
    for (int i = N - 1; i >= 0; i--) v = {v[OUT_W-W-1:0], W'(m_bank[i])};
    return v;
  endfunction

  always @(posedge clk) begin
    bit acc;
    int s;
    if (rst) begin
      model_on = 1'b1;
      for (int i = 0; i < N; i++) m_bank[i] = (i % 5 == 0) ? (1 << FB) : 0;
      cur.delete();
      {m_ready, m_busy, m_update, m_short, m_long, m_unst, m_waiting, m_drop} = '0;
      m_check_left = 0;
    end else if (model_on) begin
      acc = coeff_valid && m_ready;
      {m_update, m_short, m_long, m_unst} = '0;
      if (m_waiting) begin
        if (sample_strobe) begin
          m_bank    = pend;
          m_update  = 1'b1;
          m_waiting = 1'b0;
        end
      end else if (m_check_left > 0) begin
        s = NS - m_check_left;
        if (!stage_ok(pend[s*5+3], pend[s*5+4])) begin
          m_unst       = 1'b1;
          m_check_left = 0;
        end else begin
          m_check_left--;
          if (m_check_left == 0) m_waiting = 1'b1;
        end
      end else if (acc) begin
        if (m_drop) begin
          if (coeff_last) m_drop = 1'b0;
        end else begin
          cur.push_back(int'(coeff_in));
          if (cur.size() == N) begin
            for (int i = 0; i < N; i++) pend[i] = cur[i];
            cur.delete();
            if (!coeff_last) begin
              m_long = 1'b1;
              m_drop = 1'b1;
            end else if (CHECK_EN) m_check_left = NS;
            else m_waiting = 1'b1;
          end else if (coeff_last) begin
            m_short = 1'b1;
            cur.delete();
          end
        end
      end
      m_ready = !m_waiting && (m_check_left == 0);
      m_busy  = m_waiting || (m_check_left > 0) || m_drop;
    end
  end

  // ---------------- per-cycle compare ----------------
  int upd_cnt = 0, short_cnt = 0, long_cnt = 0, unst_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (model_on) begin
      check("coeff_out",    coeff_out, bank_vec());
      check("coeff_update", OUT_W'(coeff_update), OUT_W'(m_update));
      check("coeff_ready",  OUT_W'(coeff_ready),  OUT_W'(m_ready));
      check("busy",         OUT_W'(busy),         OUT_W'(m_busy));
      check("err_short",    OUT_W'(err_short),    OUT_W'(m_short));
      check("err_long",     OUT_W'(err_long),     OUT_W'(m_long));
      check("err_unstable", OUT_W'(err_unstable), OUT_W'(m_unst));
      if (coeff_update === 1'b1) upd_cnt++;
      if (err_short === 1'b1)    short_cnt++;
      if (err_long === 1'b1)     long_cnt++;
      if (err_unstable === 1'b1) unst_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int v, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    coeff_valid = 1'b1;
    coeff_in    = W'(v);
    coeff_last  = last;
    while (!coeff_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got ready=%0b expected 1 within 200 cycles", coeff_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    coeff_valid = 1'b0;
    coeff_last  = 1'b0;
  endtask

  task automatic strobe();
    @(negedge clk);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    coeff_valid = 1'b0;
    coeff_last = 1'b0;
    sample_strobe = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_set(input int v [N]);
    for (int i = 0; i < N; i++) send(v[i], i == N - 1);
    idle();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int rdy_hi;
    int set_a [N];
    int set_b [N];

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("ready_after_reset", OUT_W'(coeff_ready), OUT_W'(1));
    check("reset_passthru",    coeff_out, PASS);
    check("reset_s1_b0",       OUT_W'(coeff_out[5*W +: W]), OUT_W'(16384));
    check("reset_busy",        OUT_W'(busy), OUT_W'(0));

    // Basic load and commit
    upd_cnt = 0;
    for (int i = 1; i <= 10; i++) send(i, i == 10);
    idle();
    repeat (2) @(negedge clk);
    check("precommit_unchanged", coeff_out, PASS);
    check("precommit_ready_low", OUT_W'(coeff_ready), OUT_W'(0));
    strobe();
    repeat (2) @(negedge clk);
    check("set1_commit",   coeff_out, SET1);
    check("set1_s1_a2",    OUT_W'(coeff_out[9*W +: W]), OUT_W'(10));
    check("set1_upd_once", OUT_W'(upd_cnt), OUT_W'(1));

    // Short set, then a good set
    reset_dut();
    short_cnt = 0;
    upd_cnt   = 0;
    for (int i = 0; i < 4; i++) send(100 + i, i == 3);
    idle();
    repeat (2) @(negedge clk);
    check("short_pulse",    OUT_W'(short_cnt), OUT_W'(1));
    check("short_passthru", coeff_out, PASS);
    for (int i = 0; i < N; i++) set_a[i] = 21 + i;
    send_set(set_a);
    strobe();
    repeat (2) @(negedge clk);
    check("after_short_commit", coeff_out, {16'd30, 16'd29, 16'd28, 16'd27, 16'd26,
                                             16'd25, 16'd24, 16'd23, 16'd22, 16'd21});
    check("after_short_upd", OUT_W'(upd_cnt), OUT_W'(1));

    // Long set: overrun at word 10, remainder dropped
    reset_dut();
    long_cnt = 0;
    upd_cnt  = 0;
    for (int i = 1; i <= 12; i++) begin
      send(200 + i, i == 12);
      if (i == 10) begin
        #1;
        check("err_long_at_word10", OUT_W'(err_long), OUT_W'(1));
      end
    end
    idle();
    strobe();
    repeat (2) @(negedge clk);
    check("long_pulse_once", OUT_W'(long_cnt), OUT_W'(1));
    check("long_no_commit",  OUT_W'(upd_cnt), OUT_W'(0));
    check("long_passthru",   coeff_out, PASS);
    check("long_ready",      OUT_W'(coeff_ready), OUT_W'(1));

    // Pending with valid held high for 50 cycles
    reset_dut();
    upd_cnt = 0;
    for (int i = 0; i < N; i++) send(41 + i, i == N - 1);
    @(negedge clk);
    coeff_in   = W'(77);
    coeff_last = 1'b0;
    rdy_hi = 0;
    for (int c = 0; c < 50; c++) begin
      if (coeff_ready !== 1'b0) rdy_hi++;
      @(negedge clk);
    end
    check("pending_ready_low", OUT_W'(rdy_hi), OUT_W'(0));
    check("pending_no_commit", coeff_out, PASS);
    strobe();
    idle();
    repeat (2) @(negedge clk);
    check("pending_commit", coeff_out, {16'd50, 16'd49, 16'd48, 16'd47, 16'd46,
                                         16'd45, 16'd44, 16'd43, 16'd42, 16'd41});
    check("pending_upd_once", OUT_W'(upd_cnt), OUT_W'(1));

    // Reset mid-load restores pass-through and drops the partial set
    for (int i = 0; i < 5; i++) send(300 + i, 1'b0);
    idle();
    reset_dut();
    upd_cnt = 0;
    @(negedge clk);
    check("midload_reset_passthru", coeff_out, PASS);
    strobe();
    repeat (2) @(negedge clk);
    check("midload_no_commit", OUT_W'(upd_cnt), OUT_W'(0));

    // Stability screen
    reset_dut();
    upd_cnt  = 0;
    unst_cnt = 0;
    set_a = '{16384, 0, 0, 0, 0, 16384, 0, 0, -32000, 16384};
    set_b = '{16384, 0, 0, 0, 0, 16384, 0, 0, -16000, 8000};
    send_set(set_a);
    repeat (4) @(negedge clk);
    strobe();
    repeat (2) @(negedge clk);
    if (CHECK_EN) begin
      check("unstable_pulse",     OUT_W'(unst_cnt), OUT_W'(1));
      check("unstable_no_commit", OUT_W'(upd_cnt), OUT_W'(0));
      check("unstable_passthru",  coeff_out, PASS);
    end else begin
      check("nocheck_unstable_zero", OUT_W'(unst_cnt), OUT_W'(0));
      check("nocheck_commit_a1",      OUT_W'(coeff_out[8*W +: W]), OUT_W'(16'h8300));
    end
    upd_cnt = 0;
    send_set(set_b);
    repeat (4) @(negedge clk);
    strobe();
    repeat (2) @(negedge clk);
    check("stable_commit",    OUT_W'(upd_cnt), OUT_W'(1));
    check("stable_s1_a1",     OUT_W'(coeff_out[8*W +: W]), OUT_W'(16'hC180));
    check("stable_s1_a2",     OUT_W'(coeff_out[9*W +: W]), OUT_W'(16'h1F40));
    check("stable_unst_total", OUT_W'(unst_cnt), OUT_W'(CHECK_EN ? 1 : 0));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_coeff_loader.md
Name: iir_coeff_loader

Overview:
- Receives a serial stream of biquad coefficient words over a valid/ready handshake.
- Assembles a complete coefficient set in a shadow bank.
- Commits the set atomically to the active bank, but only on a sample boundary.
- Drives the parallel b0..a2 coefficient inputs of every biquad in the cascaded IIR filter, so a coefficient change never lands mid-sample.

Parameters:
- COEFF_WIDTH, 16, signed coefficient word width.
- NUM_STAGES, 2, number of cascaded biquads served.
- FRAC_BITS, 14, fractional bits of the coefficient Q-format (1.0 = 2^FRAC_BITS).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- coeff_in  in  COEFF_WIDTH  signed coefficient word.
- coeff_valid  in  1  coeff_in valid.
- coeff_last  in  1  marks final word of a set.
- coeff_ready  out  1  loader accepts a word.
- sample_strobe  in  1  one-cycle pulse at a filter sample boundary.
- coeff_out  out  NUM_STAGES*5*COEFF_WIDTH  active bank. Stage s, index k (0=b0, 1=b1, 2=b2, 3=a1, 4=a2) occupies bits [(s*5+k)*COEFF_WIDTH +: COEFF_WIDTH]. Stage 0 is the first biquad.
- coeff_update  out  1  one-cycle pulse, high in the first cycle new coeff_out is visible.
- err_short  out  1  pulse: set ended early.
- err_long  out  1  pulse: set overran.
- err_unstable  out  1  pulse: set rejected by the stability check.
- busy  out  1  state != FILL.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: every stage's b0 = 2^FRAC_BITS and all other coefficients = 0 (unity pass-through).
  - coeff_ready=0 while rst is high, 1 from the first cycle after.
  - coeff_update, all err_* and busy are 0.
  - State is FILL, word counter = 0.
- Handshake: a word transfers when coeff_valid && coeff_ready on a rising edge. coeff_in and coeff_last are sampled only then.
- Word order: stage 0 b0, b1, b2, a1, a2, then stage 1, and so on. N = 5*NUM_STAGES words per set.
- Sign convention: the denominator is 1 + a1 z^-1 + a2 z^-2.
- FILL (coeff_ready=1):
  - An accepted word writes shadow[cnt] and increments cnt.
  - coeff_last on word index < N-1: pulse err_short, cnt <- 0, stay in FILL. The active bank is untouched.
  - Word N-1 with coeff_last: go to CHECK if the optional feature is enabled, otherwise to PENDING.
  - Word N-1 without coeff_last: pulse err_long, go to DISCARD.
- DISCARD (coeff_ready=1): accepted words are dropped. The word carrying coeff_last returns the block to FILL with cnt=0.
- PENDING (coeff_ready=0): waits for sample_strobe.
  - On the cycle sample_strobe is high, active <= shadow at that edge.
  - coeff_update=1 in the next cycle, together with the new coeff_out.
  - State returns to FILL, cnt=0.
- sample_strobe in FILL, DISCARD or CHECK is ignored.
- coeff_valid in PENDING or CHECK is not accepted; the upstream holds the word.
- Latency: the last word is accepted at edge E. Without the feature, the earliest coeff_out change is at edge E+1, given sample_strobe high in the cycle after E. The feature adds NUM_STAGES cycles.
- Reset mid-load or while pending: the shadow set is discarded and the active bank returns to pass-through.
- coeff_out changes only on a commit or on reset.
- All err_* outputs are single-cycle pulses, mutually exclusive by construction.

Optional Feature:
- Macro: IIR_COEFF_STABILITY_CHECK_EN.
- With the macro, CHECK state tests one stage per cycle, stage 0 first, for NUM_STAGES cycles.
  - Condition: |a2| < 2^FRAC_BITS and |a1| < 2^FRAC_BITS + a2.
  - Compare in COEFF_WIDTH+2 bit signed arithmetic, with no overflow.
  - Any failing stage: pulse err_unstable in the cycle after the failing check, then FILL with cnt=0. The active bank is kept.
  - All stages pass: go to PENDING.
- Without the macro, the CHECK state is absent and err_unstable is tied to 0.

Decomposition:
- Package iir_pkg:
  - COEFFS_PER_STAGE=5.
  - Coefficient index constants IDX_B0..IDX_A2.
  - State encoding: FILL, DISCARD, CHECK, PENDING.
  - Unity-value helper (1 << FRAC_BITS).
- Sub-module iir_coeff_stage_check: combinational stability test of one (a1, a2) pair. Instantiated only under IIR_COEFF_STABILITY_CHECK_EN.

Test Plan:
- Reset release, defaults -> coeff_out has b0=16384 and all others 0 for both stages; coeff_ready=1 one cycle after rst falls.
- Load words 1..10 with coeff_last on word 10, sample_strobe 3 cycles later -> coeff_out unchanged until the commit; coeff_update pulses once; stage1 a2 field = 10.
- coeff_last on word 4 -> err_short pulse, coeff_out still pass-through; the next full 10-word set commits normally.
- 12 words with coeff_last on word 12 -> err_long at word 10, words 11-12 dropped, no commit; coeff_ready stays 1.
- Set complete, sample_strobe absent for 50 cycles while coeff_valid is held high -> coeff_ready=0 throughout; commit occurs on the first strobe.
- With the macro: stage 1 a1=-32000, a2=16384 -> err_unstable pulse, no coeff_update; a set with a1=-16000, a2=8000 commits.
